// File: rtl/hazard_stall_ctrl_if.sv
// Decode-stage hazard/stall bundle: the pipeline-stage fields the stall
// controller inspects, plus the stall, flush and status outputs it drives.
interface hazard_stall_ctrl_if;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic        d_is_md;
  logic        e_regwrite;
  logic [4:0]  e_waddr;
  logic [1:0]  e_tnew;
  logic        m_regwrite;
  logic [4:0]  m_waddr;
  logic [1:0]  m_tnew;
  logic        e_md_start;
  logic        e_md_is_div;
  logic        pc_en;
  logic        d_en;
  logic        e_flush;
  logic        md_busy;
  logic [31:0] stall_cnt;
  logic        proto_err;

  // Pipeline side: supplies stage fields, consumes stall controls.
  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
    output e_regwrite, e_waddr, e_tnew,
    output m_regwrite, m_waddr, m_tnew,
    output e_md_start, e_md_is_div,
    input  pc_en, d_en, e_flush, md_busy, stall_cnt, proto_err
  );

  // Stall controller side.
  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
    input  e_regwrite, e_waddr, e_tnew,
    input  m_regwrite, m_waddr, m_tnew,
    input  e_md_start, e_md_is_div,
    output pc_en, d_en, e_flush, md_busy, stall_cnt, proto_err
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage stall/flush controller for the 5-stage MIPS pipeline.
// Combines Tuse/Tnew data hazards against E and M with the occupancy of the
// multi-cycle mult/div unit. The stall controls are combinational so the
// bubble is inserted in the same cycle the hazard is seen.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [31:0]      SAT_MAX   = 32'hFFFF_FFFF;

  md_state_e          state_r;
  md_state_e          state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic               proto_err_r;
  logic               proto_set_s;
  logic [31:0]        stall_cnt_r;

  logic               hz_rs_s;
  logic               hz_rt_s;
  logic               md_busy_s;
  logic               md_stall_s;
  logic               stall_s;
  logic               pc_en_s;
  logic               d_en_s;
  logic               e_flush_s;

  // A source register is hazardous when a younger-stage producer will not have
  // its value forwardable before D needs it. $0 is hard-wired and never waits;
  // Tuse=3 (not read) can never be exceeded since Tnew tops out at 2.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic       e_rw,
    input logic [4:0] e_wa,
    input logic [1:0] e_tn,
    input logic       m_rw,
    input logic [4:0] m_wa,
    input logic [1:0] m_tn
  );
    logic e_hit;
    logic m_hit;
    e_hit = e_rw && (e_wa == src) && (e_tn > tuse);
    m_hit = m_rw && (m_wa == src) && (m_tn > tuse);
    return (src != 5'd0) && (e_hit || m_hit);
  endfunction

  // Data-hazard detection for both source operands of the instruction in D.
  always_comb begin
    hz_rs_s = src_hazard(bus.d_rs, bus.d_tuse_rs,
                         bus.e_regwrite, bus.e_waddr, bus.e_tnew,
                         bus.m_regwrite, bus.m_waddr, bus.m_tnew);
    hz_rt_s = src_hazard(bus.d_rt, bus.d_tuse_rt,
                         bus.e_regwrite, bus.e_waddr, bus.e_tnew,
                         bus.m_regwrite, bus.m_waddr, bus.m_tnew);
  end

  // Merge data and mult/div stalls into one stall request.
  always_comb begin
    md_busy_s  = (state_r == MD_BUSY);
    md_stall_s = bus.d_is_md && (bus.e_md_start || md_busy_s);
    stall_s    = hz_rs_s || hz_rt_s || md_stall_s;
  end

  // Drive fetch/decode enables and the D/E bubble; held inactive during reset.
  always_comb begin
    pc_en_s   = 1'b1;
    d_en_s    = 1'b1;
    e_flush_s = 1'b0;
    if (reset) begin
      pc_en_s   = 1'b1;
      d_en_s    = 1'b1;
      e_flush_s = 1'b0;
    end else begin
      pc_en_s   = ~stall_s;
      d_en_s    = ~stall_s;
      e_flush_s = stall_s;
    end
  end

  // Mult/div occupancy: next state, countdown and overlap-error detection.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    proto_set_s = 1'b0;
    case (state_r)
      MD_IDLE: begin
        if (bus.e_md_start) begin
          cnt_s   = bus.e_md_is_div ? DIV_LOAD : MULT_LOAD;
          state_s = MD_BUSY;
        end else begin
          cnt_s   = cnt_r;
          state_s = MD_IDLE;
        end
      end
      MD_BUSY: begin
        // A new start while busy is a pipeline protocol violation; it is
        // dropped so the running operation keeps its original length.
        if (bus.e_md_start) begin
          proto_set_s = 1'b1;
        end else begin
          proto_set_s = 1'b0;
        end
        if (cnt_r == CNT_ONE) begin
          cnt_s   = CNT_ZERO;
          state_s = MD_IDLE;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
          state_s = MD_BUSY;
        end
      end
      default: begin
        cnt_s   = CNT_ZERO;
        state_s = MD_IDLE;
      end
    endcase
  end

  // Mult/div state, countdown and sticky protocol-error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= MD_IDLE;
      cnt_r       <= CNT_ZERO;
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      proto_err_r <= proto_err_r || proto_set_s;
    end
  end

  // Saturating count of stalled cycles for performance monitoring.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && (stall_cnt_r != SAT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.pc_en     = pc_en_s;
  assign bus.d_en      = d_en_s;
  assign bus.e_flush   = e_flush_s;
  assign bus.md_busy   = md_busy_s;
  assign bus.stall_cnt = stall_cnt_r;
  assign bus.proto_err = proto_err_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl. Inputs change just after the
// falling edge and outputs are sampled 1 ns later, well before the rising edge.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if bus();

  hazard_stall_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic       e_rw;
    logic [4:0] e_wa;
    logic [1:0] e_tn;
    logic       m_rw;
    logic [4:0] m_wa;
    logic [1:0] m_tn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tu_rs;
    logic [1:0] tu_rt;
    logic       stall;
  } hz_vec_t;

  // Load-use and forwarding-distance cases that must (or must just not) stall.
  localparam hz_vec_t LU_TBL [0:6] = '{
    '{1'b1,5'd1,2'd2, 1'b0,5'd0,2'd0, 5'd1,5'd2,2'd1,2'd1, 1'b1}, // lw in E, addu rs
    '{1'b0,5'd0,2'd0, 1'b1,5'd1,2'd1, 5'd1,5'd2,2'd1,2'd1, 1'b0}, // lw in M, tnew==tuse
    '{1'b1,5'd1,2'd2, 1'b0,5'd0,2'd0, 5'd1,5'd2,2'd0,2'd0, 1'b1}, // lw in E, beq
    '{1'b0,5'd0,2'd0, 1'b1,5'd1,2'd1, 5'd1,5'd2,2'd0,2'd0, 1'b1}, // lw in M, beq held
    '{1'b0,5'd0,2'd0, 1'b1,5'd1,2'd0, 5'd1,5'd2,2'd0,2'd0, 1'b0}, // M tnew=0 released
    '{1'b1,5'd1,2'd1, 1'b0,5'd0,2'd0, 5'd1,5'd2,2'd0,2'd0, 1'b1}, // ALU in E, beq
    '{1'b1,5'd7,2'd2, 1'b0,5'd0,2'd0, 5'd3,5'd7,2'd0,2'd1, 1'b1}  // rt hazard from E
  };

  // Cases that look like hazards but must not stall, plus an M-stage rt hit.
  localparam hz_vec_t NS_TBL [0:5] = '{
    '{1'b1,5'd0,2'd2, 1'b1,5'd0,2'd1, 5'd0,5'd0,2'd0,2'd0, 1'b0}, // $0 never stalls
    '{1'b1,5'd1,2'd2, 1'b1,5'd1,2'd1, 5'd1,5'd1,2'd3,2'd3, 1'b0}, // tuse=3 not read
    '{1'b0,5'd1,2'd2, 1'b0,5'd1,2'd1, 5'd1,5'd1,2'd0,2'd0, 1'b0}, // no regwrite
    '{1'b1,5'd2,2'd2, 1'b1,5'd4,2'd1, 5'd1,5'd3,2'd0,2'd0, 1'b0}, // address mismatch
    '{1'b1,5'd1,2'd1, 1'b0,5'd0,2'd0, 5'd1,5'd1,2'd1,2'd1, 1'b0}, // tnew==tuse in E
    '{1'b0,5'd0,2'd0, 1'b1,5'd9,2'd1, 5'd2,5'd9,2'd2,2'd0, 1'b1}  // rt hazard from M
  };

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic idle_inputs();
    bus.d_rs        = 5'd0;
    bus.d_rt        = 5'd0;
    bus.d_tuse_rs   = 2'd3;
    bus.d_tuse_rt   = 2'd3;
    bus.d_is_md     = 1'b0;
    bus.e_regwrite  = 1'b0;
    bus.e_waddr     = 5'd0;
    bus.e_tnew      = 2'd0;
    bus.m_regwrite  = 1'b0;
    bus.m_waddr     = 5'd0;
    bus.m_tnew      = 2'd0;
    bus.e_md_start  = 1'b0;
    bus.e_md_is_div = 1'b0;
  endtask

  task automatic apply_hz(input hz_vec_t v);
    bus.e_regwrite = v.e_rw;
    bus.e_waddr    = v.e_wa;
    bus.e_tnew     = v.e_tn;
    bus.m_regwrite = v.m_rw;
    bus.m_waddr    = v.m_wa;
    bus.m_tnew     = v.m_tn;
    bus.d_rs       = v.rs;
    bus.d_rt       = v.rt;
    bus.d_tuse_rs  = v.tu_rs;
    bus.d_tuse_rt  = v.tu_rt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    apply_hz(LU_TBL[0]);
    #1;
    total++;
    if ({bus.pc_en, bus.d_en, bus.e_flush} !== 3'b110) begin
      bad++;
      $display("FAIL reset_forced_ctl got=%b exp=%b", {bus.pc_en, bus.d_en, bus.e_flush}, 3'b110);
    end
    total++;
    if ({bus.md_busy, bus.proto_err, bus.stall_cnt} !== {2'b00, 32'd0}) begin
      bad++;
      $display("FAIL reset_state got busy=%b err=%b cnt=%h exp 0/0/0", bus.md_busy, bus.proto_err, bus.stall_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    total++;
    if ({bus.pc_en, bus.d_en, bus.e_flush, bus.stall_cnt} !== {3'b110, 32'd0}) begin
      bad++;
      $display("FAIL post_reset got ctl=%b cnt=%h exp ctl=110 cnt=0", {bus.pc_en, bus.d_en, bus.e_flush}, bus.stall_cnt);
    end
    exp_cnt = 32'd0;
  endtask

  task automatic test_data_hazard();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      idle_inputs();
      apply_hz(LU_TBL[i]);
      #1;
      total++;
      if ({bus.pc_en, bus.d_en, bus.e_flush} !== {~LU_TBL[i].stall, ~LU_TBL[i].stall, LU_TBL[i].stall}) begin
        bad++;
        $display("FAIL load_use[%0d] got ctl=%b exp stall=%b", i, {bus.pc_en, bus.d_en, bus.e_flush}, LU_TBL[i].stall);
      end
      if (LU_TBL[i].stall) exp_cnt = exp_cnt + 32'd1;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (bus.stall_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL load_use_cnt got=%0d exp=%0d", bus.stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_no_stall();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_inputs();
      apply_hz(NS_TBL[i]);
      #1;
      total++;
      if ({bus.pc_en, bus.d_en, bus.e_flush} !== {~NS_TBL[i].stall, ~NS_TBL[i].stall, NS_TBL[i].stall}) begin
        bad++;
        $display("FAIL no_stall[%0d] got ctl=%b exp stall=%b", i, {bus.pc_en, bus.d_en, bus.e_flush}, NS_TBL[i].stall);
      end
      if (NS_TBL[i].stall) exp_cnt = exp_cnt + 32'd1;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (bus.stall_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL no_stall_cnt got=%0d exp=%0d", bus.stall_cnt, exp_cnt);
    end
  endtask

  // mult start with mflo waiting in D; the start cycle also carries a data
  // hazard to show coincident causes still cost one stall cycle.
  task automatic test_md_mult();
    logic exp_stall;
    logic exp_busy;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      idle_inputs();
      bus.d_is_md = 1'b1;
      if (i == 0) begin
        bus.e_md_start  = 1'b1;
        bus.e_md_is_div = 1'b0;
        apply_hz(LU_TBL[0]);
      end
      exp_stall = (i <= 5);
      exp_busy  = (i >= 1) && (i <= 5);
      #1;
      total++;
      if ({bus.md_busy, bus.pc_en, bus.d_en, bus.e_flush} !== {exp_busy, ~exp_stall, ~exp_stall, exp_stall}) begin
        bad++;
        $display("FAIL mult_cycle[%0d] got busy=%b ctl=%b exp busy=%b stall=%b", i, bus.md_busy, {bus.pc_en, bus.d_en, bus.e_flush}, exp_busy, exp_stall);
      end
      if (exp_stall) exp_cnt = exp_cnt + 32'd1;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if ({bus.stall_cnt, bus.proto_err} !== {exp_cnt, 1'b0}) begin
      bad++;
      $display("FAIL mult_cnt got cnt=%0d err=%b exp cnt=%0d err=0", bus.stall_cnt, bus.proto_err, exp_cnt);
    end
  endtask

  task automatic test_md_div_reset();
    logic exp_busy;
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i == 0) begin
        bus.e_md_start  = 1'b1;
        bus.e_md_is_div = 1'b1;
      end
      exp_busy = (i >= 1) && (i <= 10);
      #1;
      total++;
      if ({bus.md_busy, bus.e_flush} !== {exp_busy, 1'b0}) begin
        bad++;
        $display("FAIL div_cycle[%0d] got busy=%b flush=%b exp busy=%b flush=0", i, bus.md_busy, bus.e_flush, exp_busy);
      end
    end
    // Second div, stalled by mfhi, aborted by reset on its fourth busy cycle.
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i == 0) begin
        bus.e_md_start  = 1'b1;
        bus.e_md_is_div = 1'b1;
      end else begin
        bus.d_is_md = 1'b1;
        exp_cnt = exp_cnt + 32'd1;
      end
    end
    @(negedge clk);
    idle_inputs();
    bus.d_is_md = 1'b1;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.md_busy, bus.pc_en, bus.d_en, bus.e_flush, bus.stall_cnt} !== {4'b1110, exp_cnt}) begin
      bad++;
      $display("FAIL div_reset_cycle got busy=%b ctl=%b cnt=%0d exp busy=1 ctl=110 cnt=%0d", bus.md_busy, {bus.pc_en, bus.d_en, bus.e_flush}, bus.stall_cnt, exp_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    exp_cnt = 32'd0;
    total++;
    if ({bus.md_busy, bus.stall_cnt} !== {1'b0, exp_cnt}) begin
      bad++;
      $display("FAIL div_after_reset got busy=%b cnt=%0d exp busy=0 cnt=0", bus.md_busy, bus.stall_cnt);
    end
  endtask

  task automatic test_proto_err();
    logic exp_busy;
    logic exp_err;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i == 0) begin
        bus.e_md_start  = 1'b1;
        bus.e_md_is_div = 1'b0;
      end else if (i == 2) begin
        bus.e_md_start  = 1'b1;
        bus.e_md_is_div = 1'b1;
      end
      exp_busy = (i >= 1) && (i <= 5);
      exp_err  = (i >= 3);
      #1;
      total++;
      if ({bus.md_busy, bus.proto_err} !== {exp_busy, exp_err}) begin
        bad++;
        $display("FAIL proto_cycle[%0d] got busy=%b err=%b exp busy=%b err=%b", i, bus.md_busy, bus.proto_err, exp_busy, exp_err);
      end
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    idle_inputs();
    apply_hz(LU_TBL[0]);
    force dut.stall_cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_r;
    total++;
    if (bus.stall_cnt !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL sat_preload got=%h exp=%h", bus.stall_cnt, 32'hFFFF_FFFE);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      total++;
      if ({bus.e_flush, bus.stall_cnt} !== {1'b1, 32'hFFFF_FFFF}) begin
        bad++;
        $display("FAIL sat_hold[%0d] got flush=%b cnt=%h exp flush=1 cnt=ffffffff", k, bus.e_flush, bus.stall_cnt);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_data_hazard();
    test_no_stall();
    test_md_mult();
    test_md_div_reset();
    test_proto_err();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
